// File: rtl/cacheline_adaptor_pkg.sv
// ============================================================================
// cacheline_adaptor_pkg : shared types and sizing for the cache-line adaptor
// Rev 1.0
// ============================================================================
`default_nettype none

package cacheline_adaptor_pkg;

   localparam int unsigned S_LINE  = 256;
   localparam int unsigned S_BURST = 64;
   localparam int unsigned BEATS   = S_LINE / S_BURST;

   typedef logic [1:0] beat_cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/cacheline_adaptor_if.sv
// ============================================================================
// cacheline_adaptor_if : cache-side pmem_* and memory-side burst signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface cacheline_adaptor_if
   import cacheline_adaptor_pkg::*;
#(
   parameter int s_line  = S_LINE,
   parameter int s_burst = S_BURST
);

   logic [s_line-1:0]  line_i;
   logic [s_line-1:0]  line_o;
   logic [31:0]        address_i;
   logic               read_i;
   logic               write_i;
   logic               resp_o;
   logic [s_burst-1:0] burst_i;
   logic [s_burst-1:0] burst_o;
   logic [31:0]        address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i;

   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );

endinterface

`default_nettype wire

// File: rtl/cacheline_adaptor.sv
// ============================================================================
// cacheline_adaptor : bridges one cache line to a multi-beat memory burst
// Rev 1.0
// ============================================================================
`default_nettype none

module cacheline_adaptor
   import cacheline_adaptor_pkg::*;
#(
   parameter int s_line  = S_LINE,
   parameter int s_burst = S_BURST
) (
   input  wire logic          clk,
   input  wire logic          rst,
   cacheline_adaptor_if.slave bus
);

   localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(s_line / s_burst - 1);

   state_e            state_q, state_d;
   beat_cnt_t         cnt_q,   cnt_d;
   logic [31:0]       addr_q,  addr_d;
   logic [s_line-1:0] wline_q, wline_d;
   logic [s_line-1:0] rline_q, rline_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wline_d = wline_q;
      rline_d = rline_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.write_i) begin
               addr_d  = bus.address_i & 32'hFFFF_FFE0;
               wline_d = bus.line_i;
               cnt_d   = '0;
               state_d = ST_WRITE;
            end else if (bus.read_i) begin
               addr_d  = bus.address_i & 32'hFFFF_FFE0;
               cnt_d   = '0;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (bus.resp_i) begin
               rline_d[int'(cnt_q)*s_burst +: s_burst] = bus.burst_i;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == LAST_BEAT) state_d = ST_DONE;
            end
         end
         ST_WRITE: begin
            if (bus.resp_i) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == LAST_BEAT) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wline_q <= wline_d;
         rline_q <= rline_d;
      end
   end

   // Outputs decode straight from state so they fall the cycle the FSM leaves READ/WRITE.
   assign bus.read_o    = (state_q == ST_READ);
   assign bus.write_o   = (state_q == ST_WRITE);
   assign bus.resp_o    = (state_q == ST_DONE);
   assign bus.address_o = (state_q == ST_READ || state_q == ST_WRITE) ? addr_q : 32'h0;
   assign bus.burst_o   = (state_q == ST_WRITE) ? wline_q[int'(cnt_q)*s_burst +: s_burst]
                                                : '0;
   assign bus.line_o    = rline_q;

endmodule

`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
// ============================================================================
// tb_cacheline_adaptor : vector table, corner sequences and random traffic
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cacheline_adaptor;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [255:0] exp_line = '0;

   cacheline_adaptor_if #(.s_line(256), .s_burst(64)) bus();

   cacheline_adaptor #(.s_line(256), .s_burst(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit           is_wr;
      bit           both;
      logic [31:0]  addr;
      logic [31:0]  exp_addr;
      logic [255:0] line;
      logic [15:0]  pat;
      int           plen;
      int           exp_cycles;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] beat(input logic [255:0] l, input int k);
      return l[k*64 +: 64];
   endfunction

   // Cycles from entering READ/WRITE to the cycle carrying the fourth accepted beat.
   function automatic int cycles_for(input logic [15:0] pat, input int plen);
      int ones = 0;
      for (int i = 0; i < 64; i++) begin
         if (i >= plen || pat[i]) ones++;
         if (ones == 4) return i + 1;
      end
      return -1;
   endfunction

   task automatic run_txn(input bit is_wr, input bit both, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [255:0] line,
                          input logic [15:0] pat, input int plen, input int exp_cycles,
                          input bit rnd, input string tag);
      int k = 0;
      int cyc = 0;
      bit r;
      @(negedge clk);
      bus.address_i = addr;
      bus.line_i    = is_wr ? line : {8{$urandom()}};
      bus.write_i   = is_wr;
      bus.read_i    = !is_wr || both;
      bus.resp_i    = 1'b1;
      @(negedge clk);
      while (k < 4 && cyc < 64) begin
         chk({tag, " read_o"},    256'(bus.read_o),    256'(!is_wr));
         chk({tag, " write_o"},   256'(bus.write_o),   256'(is_wr));
         chk({tag, " address_o"}, 256'(bus.address_o), 256'(exp_addr));
         chk({tag, " resp_o"},    256'(bus.resp_o),    256'(0));
         chk({tag, " burst_o"},   256'(bus.burst_o),   is_wr ? 256'(beat(line, k)) : 256'(0));
         if (is_wr) chk({tag, " line_o held"}, bus.line_o, exp_line);
         r = (cyc < plen) ? pat[cyc] : 1'b1;
         bus.resp_i    = r;
         bus.burst_i   = is_wr ? 64'({$urandom(), $urandom()}) : beat(line, k);
         bus.read_i    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.write_i   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.address_i = $urandom();
         bus.line_i    = {8{$urandom()}};
         if (r) k++;
         cyc++;
         @(negedge clk);
      end
      chk({tag, " beats before timeout"}, 256'(k), 256'(4));
      chk({tag, " cycles"}, 256'(cyc), 256'(exp_cycles));
      if (!is_wr) exp_line = line;
      chk({tag, " done resp_o"},    256'(bus.resp_o),    256'(1));
      chk({tag, " done read_o"},    256'(bus.read_o),    256'(0));
      chk({tag, " done write_o"},   256'(bus.write_o),   256'(0));
      chk({tag, " done address_o"}, 256'(bus.address_o), 256'(0));
      chk({tag, " done burst_o"},   256'(bus.burst_o),   256'(0));
      chk({tag, " done line_o"},    bus.line_o,          exp_line);
      bus.resp_i  = 1'($urandom_range(0, 1));
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      @(negedge clk);
      chk({tag, " idle resp_o"},  256'(bus.resp_o),  256'(0));
      chk({tag, " idle read_o"},  256'(bus.read_o),  256'(0));
      chk({tag, " idle write_o"}, 256'(bus.write_o), 256'(0));
      chk({tag, " idle line_o"},  bus.line_o,        exp_line);
      bus.resp_i = 1'b0;
   endtask

   initial begin
      vecs[0] = '{is_wr: 1'b0, both: 1'b0, addr: 32'h0000_1000, exp_addr: 32'h0000_1000,
                  line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  pat: 16'hFFFF, plen: 4, exp_cycles: 4};
      vecs[1] = '{is_wr: 1'b1, both: 1'b0, addr: 32'h0000_1234, exp_addr: 32'h0000_1220,
                  line: {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                         64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0},
                  pat: 16'hFFFF, plen: 4, exp_cycles: 4};
      // Stall pattern 1,0,0,1,1,0,1 listed LSB first.
      vecs[2] = '{is_wr: 1'b0, both: 1'b0, addr: 32'hABCD_EF7F, exp_addr: 32'hABCD_EF60,
                  line: {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                         64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001},
                  pat: 16'b0000_0000_0101_1001, plen: 7, exp_cycles: 7};
      vecs[3] = '{is_wr: 1'b1, both: 1'b1, addr: 32'h8000_001F, exp_addr: 32'h8000_0000,
                  line: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                         64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0},
                  pat: 16'b0000_0000_0000_0110, plen: 4, exp_cycles: 6};

      rst = 1'b0;
      bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
      bus.burst_i = '0; bus.resp_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset read_o",    256'(bus.read_o),    256'(0));
      chk("reset write_o",   256'(bus.write_o),   256'(0));
      chk("reset resp_o",    256'(bus.resp_o),    256'(0));
      chk("reset address_o", 256'(bus.address_o), 256'(0));
      chk("reset burst_o",   256'(bus.burst_o),   256'(0));
      chk("reset line_o",    bus.line_o,          256'(0));
      rst = 1'b1;

      // Stray memory handshakes while idle must not start anything.
      @(negedge clk);
      bus.resp_i = 1'b1;
      @(negedge clk);
      chk("idle resp_i read_o", 256'(bus.read_o), 256'(0));
      chk("idle resp_i resp_o", 256'(bus.resp_o), 256'(0));
      bus.resp_i = 1'b0;

      for (int i = 0; i < 4; i++)
         run_txn(vecs[i].is_wr, vecs[i].both, vecs[i].addr, vecs[i].exp_addr, vecs[i].line,
                 vecs[i].pat, vecs[i].plen, vecs[i].exp_cycles, 1'b0, $sformatf("vec%0d", i));

      // Reset pulled while the second read beat is on the bus.
      @(negedge clk);
      bus.read_i = 1'b1; bus.address_i = 32'h0000_4040; bus.resp_i = 1'b0;
      @(negedge clk);
      bus.read_i = 1'b0; bus.resp_i = 1'b1; bus.burst_i = 64'h9999_9999_9999_9999;
      @(negedge clk);
      bus.burst_i = 64'h8888_8888_8888_8888;
      rst = 1'b0;
      #1;
      chk("abort read_o",    256'(bus.read_o),    256'(0));
      chk("abort address_o", 256'(bus.address_o), 256'(0));
      chk("abort line_o",    bus.line_o,          256'(0));
      @(negedge clk);
      chk("abort resp_o",    256'(bus.resp_o),    256'(0));
      rst = 1'b1; bus.resp_i = 1'b0;
      @(negedge clk);
      chk("after abort resp_o", 256'(bus.resp_o), 256'(0));
      chk("after abort read_o", 256'(bus.read_o), 256'(0));
      exp_line = '0;
      run_txn(1'b0, 1'b0, 32'h0000_4040, 32'h0000_4040, vecs[0].line, 16'hFFFF, 4, 4,
              1'b0, "post-abort");

      for (int n = 0; n < 30; n++) begin
         logic [31:0]  a;
         logic [255:0] l;
         logic [15:0]  p;
         bit           w;
         a = $urandom();
         l = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
         p = 16'($urandom());
         w = 1'($urandom_range(0, 1));
         run_txn(w, 1'($urandom_range(0, 1)), a, {a[31:5], 5'b0}, l, p, 12,
                 cycles_for(p, 12), 1'b1, $sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
